// File: rtl/lighthouse_pulse_decoder.sv
// Lighthouse envelope decoder: measures active-low E pulses from the TS4231 and
// classifies them as sync (3-bit OOTX code), sweep or glitch, timestamping sweeps.
module lighthouse_pulse_decoder #(
    parameter int unsigned CLK_FREQ_HZ      = 48_000_000,
    parameter int unsigned TS_W             = 20,
    parameter int unsigned MIN_PULSE_CLK    = CLK_FREQ_HZ / 2_000_000,
    parameter int unsigned SYNC_LO_CLK      = 2750,
    parameter int unsigned SYNC_STEP_CLK    = 500,
    parameter int unsigned PAIR_GAP_CLK     = CLK_FREQ_HZ / 2500,
    parameter int unsigned LOCK_TIMEOUT_CLK = CLK_FREQ_HZ / 50
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_done,
    input  logic            e_in,
    output logic            sync_valid,
    output logic [2:0]      sync_code,
    output logic            sync_slot,
    output logic            sweep_valid,
    output logic [TS_W-1:0] sweep_time,
    output logic            sweep_axis,
    output logic            sweep_lh,
    output logic [15:0]     sweep_width,
    output logic            locked,
    output logic            err_pulse
);

    localparam int unsigned LT_W = $clog2(LOCK_TIMEOUT_CLK + 1);

    typedef enum logic [1:0] {IDLE, WAIT_FALL, IN_PULSE, CLASSIFY} state_t;

    state_t            state_q;
    logic              e_s1_q, e_s2_q, e_prev_q;
    logic [TS_W-1:0]   ts_q, pulse_start_q, sync_start_q, last_sync_end_q;
    logic [15:0]       width_q;
    logic              prev_slot_q, ref_axis_q, ref_lh_q;
    logic [LT_W-1:0]   lock_tmr_q;

    logic              sync_valid_q, sync_slot_q, sweep_valid_q, sweep_axis_q;
    logic              sweep_lh_q, locked_q, err_pulse_q;
    logic [2:0]        sync_code_q;
    logic [TS_W-1:0]   sweep_time_q;
    logic [15:0]       sweep_width_q;

    logic [31:0]       w32;
    logic [2:0]        code_d;
    logic [TS_W-1:0]   gap_d, sweep_time_d;
    logic              slot_d, is_glitch, is_sweep, is_err;

    always_comb begin
        w32    = {16'h0000, width_q};
        code_d = '0;
        // Code is the number of step thresholds crossed: seven compares, no divider.
        for (int unsigned k = 1; k < 8; k++) begin
            if (w32 >= SYNC_LO_CLK + k * SYNC_STEP_CLK) code_d = code_d + 3'd1;
        end
        is_glitch    = w32 < MIN_PULSE_CLK;
        is_sweep     = !is_glitch && (w32 < SYNC_LO_CLK);
        is_err       = (w32 >= SYNC_LO_CLK + 8 * SYNC_STEP_CLK) || (width_q == 16'hFFFF);
        gap_d        = pulse_start_q - last_sync_end_q;
        slot_d       = (32'(gap_d) < PAIR_GAP_CLK) && !prev_slot_q;
        sweep_time_d = pulse_start_q + TS_W'(width_q >> 1) - sync_start_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            e_s1_q          <= 1'b1;
            e_s2_q          <= 1'b1;
            e_prev_q        <= 1'b1;
            ts_q            <= '0;
            pulse_start_q   <= '0;
            sync_start_q    <= '0;
            last_sync_end_q <= '0;
            width_q         <= '0;
            prev_slot_q     <= 1'b1;
            ref_axis_q      <= 1'b0;
            ref_lh_q        <= 1'b0;
            lock_tmr_q      <= '0;
            sync_valid_q    <= 1'b0;
            sync_code_q     <= '0;
            sync_slot_q     <= 1'b0;
            sweep_valid_q   <= 1'b0;
            sweep_time_q    <= '0;
            sweep_axis_q    <= 1'b0;
            sweep_lh_q      <= 1'b0;
            sweep_width_q   <= '0;
            locked_q        <= 1'b0;
            err_pulse_q     <= 1'b0;
        end else begin
            e_s1_q        <= e_in;
            e_s2_q        <= e_s1_q;
            e_prev_q      <= e_s2_q;
            ts_q          <= ts_q + TS_W'(1);
            sync_valid_q  <= 1'b0;
            sweep_valid_q <= 1'b0;
            err_pulse_q   <= 1'b0;

            if (lock_tmr_q != LT_W'(LOCK_TIMEOUT_CLK)) lock_tmr_q <= lock_tmr_q + LT_W'(1);
            else                                       locked_q   <= 1'b0;

            if (!cfg_done) begin
                // Pairing history is meaningless after a configuration drop.
                state_q     <= IDLE;
                locked_q    <= 1'b0;
                prev_slot_q <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: if (e_s2_q) state_q <= WAIT_FALL;
                    WAIT_FALL: begin
                        if (e_prev_q && !e_s2_q) begin
                            pulse_start_q <= ts_q;
                            width_q       <= 16'd1;
                            state_q       <= IN_PULSE;
                        end
                    end
                    IN_PULSE: begin
                        if (!e_prev_q && e_s2_q)     state_q <= CLASSIFY;
                        else if (width_q != 16'hFFFF) width_q <= width_q + 16'd1;
                    end
                    CLASSIFY: begin
                        state_q <= WAIT_FALL;
                        if (is_err) begin
                            err_pulse_q <= 1'b1;
                        end else if (!is_glitch && !is_sweep) begin
                            sync_valid_q    <= 1'b1;
                            sync_code_q     <= code_d;
                            sync_slot_q     <= slot_d;
                            prev_slot_q     <= slot_d;
                            last_sync_end_q <= ts_q;
                            if (!code_d[2]) begin
                                sync_start_q <= pulse_start_q;
                                ref_axis_q   <= code_d[0];
                                ref_lh_q     <= slot_d;
                                locked_q     <= 1'b1;
                                lock_tmr_q   <= '0;
                            end
                        end else if (is_sweep && locked_q) begin
                            sweep_valid_q <= 1'b1;
                            sweep_time_q  <= sweep_time_d;
                            sweep_axis_q  <= ref_axis_q;
                            sweep_lh_q    <= ref_lh_q;
                            sweep_width_q <= width_q;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sync_valid  = sync_valid_q;
    assign sync_code   = sync_code_q;
    assign sync_slot   = sync_slot_q;
    assign sweep_valid = sweep_valid_q;
    assign sweep_time  = sweep_time_q;
    assign sweep_axis  = sweep_axis_q;
    assign sweep_lh    = sweep_lh_q;
    assign sweep_width = sweep_width_q;
    assign locked      = locked_q;
    assign err_pulse   = err_pulse_q;

endmodule
